nn_wmem_arbiter: RTL and testbench
==================================

Name: nn_wmem_arbiter

Overview:
- Arbitrates one port of a 32x32 dual-port weight/kernel SRAM between two requesters.
  - Learn loader: burst writes.
  - Classify engine: burst reads.
- Generates active-low SRAM controls (CSB/WEB/OEB) and a wrapping address counter.
- Returns read data with a valid strobe.
- Sits between the neural-net controller and a dpram32x32_cb port; one instance per memory port.

Parameters:
- ADDR_W, 5, SRAM address width; depth = 2**ADDR_W, addresses wrap mod depth.
- DATA_W, 32, SRAM word width.
- LEN_W, 6, burst-length field width; max legal length = 2**ADDR_W.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- ld_req  in  1  loader burst request; held high until ld_gnt
- ld_addr  in  ADDR_W  loader start address, sampled on grant
- ld_len  in  LEN_W  loader burst length in words, sampled on grant
- ld_wdata  in  DATA_W  write word
- ld_wvalid  in  1  write word valid this cycle
- ld_gnt  out  1  one-cycle pulse: loader burst accepted
- ld_wready  out  1  high while loader owns the port; a word transfers when ld_wvalid & ld_wready
- ld_done  out  1  one-cycle pulse after the last write
- cl_req  in  1  classify burst request; held until cl_gnt
- cl_addr  in  ADDR_W  classify start address, sampled on grant
- cl_len  in  LEN_W  classify burst length, sampled on grant
- cl_gnt  out  1  one-cycle pulse: classify burst accepted
- cl_rdata  out  DATA_W  read word, registered
- cl_rvalid  out  1  cl_rdata valid
- cl_done  out  1  pulse coincident with the last cl_rvalid
- MEM_A  out  ADDR_W  SRAM address
- MEM_CSB  out  1  chip select, active low
- MEM_WEB  out  1  write enable, active low
- MEM_OEB  out  1  output enable, active low
- MEM_IDATA  out  DATA_W  SRAM write data
- MEM_ODATA  in  DATA_W  SRAM read data, valid the cycle after a read access
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - MEM_CSB = MEM_WEB = MEM_OEB = 1; MEM_A = 0; MEM_IDATA = 0.
  - All gnt/done/valid/ready = 0; cl_rdata = 0; busy = 0.
  - FSM = IDLE; last_owner = CL, so the loader wins the first tie.
- A reset asserted mid-burst abandons the burst: no done pulse; controls deassert on the next edge.
- States: IDLE, LD_BURST, CL_BURST, CL_DRAIN.
- IDLE:
  - One requester: grant it.
  - Both requesting: round-robin; grant the requester that is not last_owner.
  - On grant:
    - pulse gnt; latch start address into addr counter and length into beat counter;
    - update last_owner;
    - go to LD_BURST or CL_BURST on the next cycle.
  - Length 0: gnt then done on the next cycle, no SRAM access, return to IDLE.
  - Length > 2**ADDR_W: clamped to 2**ADDR_W.
- LD_BURST:
  - ld_wready = 1.
  - Cycle with ld_wvalid = 1: MEM_CSB = 0, MEM_WEB = 0, MEM_OEB = 1, MEM_A = addr, MEM_IDATA = ld_wdata; addr increments with wrap (31 -> 0); beat counter decrements.
  - Cycle with ld_wvalid = 0: MEM_CSB = 1, no access (stall, no timeout).
  - After the final beat: ld_done pulses the next cycle, state returns to IDLE, and ld_wready falls in that same cycle.
- CL_BURST:
  - One read per cycle, no stalls: MEM_CSB = 0, MEM_OEB = 0, MEM_WEB = 1, MEM_A = addr; addr increments with wrap.
  - One cycle after each access: cl_rvalid = 1, cl_rdata = MEM_ODATA (registered capture).
  - After the last access, go to CL_DRAIN.
- CL_DRAIN:
  - MEM_CSB = 1; final cl_rvalid and cl_done are asserted together.
  - Next cycle: IDLE.
- Latency:
  - Grant: 1 cycle after req is seen in IDLE.
  - Read burst of N words: first rvalid 2 cycles after gnt, last rvalid N+1 cycles after gnt.
- Requests arriving while busy are held (req stays high) and arbitrated at the next IDLE.
- The FSM passes through IDLE for one cycle between bursts.
- WEB and OEB are never both low; CSB is high whenever no access occurs.

Optional Feature:
- Macro LEARN_PRIORITY_EN.
- Defined: fixed priority; the loader always wins a tie in IDLE; last_owner is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then ld_req, addr = 3, len = 4, wvalid continuous, data 0xA0..0xA3:
  - ld_gnt pulse; four writes to 3, 4, 5, 6 with WEB = 0; ld_done 1 cycle after the last write.
  - Then cl burst addr = 3, len = 4: cl_rvalid 4 cycles carrying 0xA0..0xA3; cl_done on the 4th.
- Write burst addr = 30, len = 4: accesses at 30, 31, 0, 1 (wrap); a read-back confirms the data.
- ld_wvalid toggling 1, 0, 0, 1, 1 with len = 3:
  - CSB high on the two gap cycles; exactly 3 writes; done after the third.
- ld_req and cl_req high together for three rounds (macro off):
  - grants ordered LD, CL, LD.
  - With LEARN_PRIORITY_EN defined: LD every round while ld_req is reasserted.
- cl len = 0: cl_gnt then cl_done next cycle; MEM_CSB stays 1 throughout.
- rst asserted in cycle 2 of an 8-word read:
  - next edge: CSB/OEB = 1, busy = 0, no cl_done.
  - A following ld request is granted normally.

Source files
------------

// File: rtl/nn_wmem_arbiter.sv
// nn_wmem_arbiter: arbitrates one port of a 32x32 weight SRAM between the learn loader and the classify engine
//
// Build option: define LEARN_PRIORITY_EN for fixed loader priority on ties,
// otherwise ties are resolved round-robin.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   ld_req/ld_addr/ld_len       loader burst request, start address, length
//   ld_wdata/ld_wvalid          loader write word and its valid
//   ld_gnt/ld_wready/ld_done    loader grant pulse, write ready, completion pulse
//   cl_req/cl_addr/cl_len       classify burst request, start address, length
//   cl_gnt/cl_rdata/cl_rvalid   classify grant pulse, read word and its valid
//   cl_done                     classify completion, coincident with last cl_rvalid
//   MEM_A/MEM_CSB/MEM_WEB/MEM_OEB/MEM_IDATA/MEM_ODATA  SRAM port, active-low controls
//   busy                        high whenever a burst is in progress
module nn_wmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_wvalid,
    output logic              ld_gnt,
    output logic              ld_wready,
    output logic              ld_done,
    input  logic              cl_req,
    input  logic [ADDR_W-1:0] cl_addr,
    input  logic [LEN_W-1:0]  cl_len,
    output logic              cl_gnt,
    output logic [DATA_W-1:0] cl_rdata,
    output logic              cl_rvalid,
    output logic              cl_done,
    output logic [ADDR_W-1:0] MEM_A,
    output logic              MEM_CSB,
    output logic              MEM_WEB,
    output logic              MEM_OEB,
    output logic [DATA_W-1:0] MEM_IDATA,
    input  logic [DATA_W-1:0] MEM_ODATA,
    output logic              busy
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, LD_BURST, CL_BURST, CL_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic              ld_gnt_q, cl_gnt_q;
    logic              ld_done_q, ld_done_d;
    logic              cl_done_q, cl_done_d;
    logic              rvalid_q;
    logic              arb_en, pick_ld, pick_cl, wr_en, rd_en;
    logic [LEN_W-1:0]  req_len;

    // The grant-pulse cycle is spent in IDLE without re-arbitrating, so the
    // burst state starts one cycle after the grant.
    assign arb_en  = (state_q == IDLE) & ~ld_gnt_q & ~cl_gnt_q;
`ifdef LEARN_PRIORITY_EN
    assign pick_ld = arb_en & ld_req;
`else
    logic last_cl_q;
    assign pick_ld = arb_en & ld_req & (~cl_req | last_cl_q);
    always_ff @(posedge clk) begin
        if (rst)
            last_cl_q <= 1'b1;
        else if (arb_en & (ld_req | cl_req))
            last_cl_q <= ~pick_ld;
    end
`endif
    assign pick_cl = arb_en & cl_req & ~pick_ld;
    assign req_len = pick_ld ? ld_len : cl_len;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        ld_done_d = 1'b0;
        cl_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_ld | pick_cl) begin
                    addr_d  = pick_ld ? ld_addr : cl_addr;
                    beats_d = (req_len > MAX_LEN) ? MAX_LEN : req_len;
                end else if (ld_gnt_q) begin
                    ld_done_d = (beats_q == '0);
                    state_d   = (beats_q == '0) ? IDLE : LD_BURST;
                end else if (cl_gnt_q) begin
                    cl_done_d = (beats_q == '0);
                    state_d   = (beats_q == '0) ? IDLE : CL_BURST;
                end
            end
            LD_BURST: begin
                if (ld_wvalid) begin
                    addr_d    = addr_q + 1'b1;
                    beats_d   = beats_q - 1'b1;
                    ld_done_d = (beats_q == ONE);
                    state_d   = (beats_q == ONE) ? IDLE : LD_BURST;
                end
            end
            CL_BURST: begin
                addr_d    = addr_q + 1'b1;
                beats_d   = beats_q - 1'b1;
                cl_done_d = (beats_q == ONE);
                state_d   = (beats_q == ONE) ? CL_DRAIN : CL_BURST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            beats_q   <= '0;
            ld_gnt_q  <= 1'b0;
            cl_gnt_q  <= 1'b0;
            ld_done_q <= 1'b0;
            cl_done_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            ld_gnt_q  <= pick_ld;
            cl_gnt_q  <= pick_cl;
            ld_done_q <= ld_done_d;
            cl_done_q <= cl_done_d;
            rvalid_q  <= rd_en;
        end
    end

    assign wr_en     = (state_q == LD_BURST) & ld_wvalid;
    assign rd_en     = (state_q == CL_BURST);
    assign MEM_CSB   = ~(wr_en | rd_en);
    assign MEM_WEB   = ~wr_en;
    assign MEM_OEB   = ~rd_en;
    assign MEM_A     = addr_q;
    assign MEM_IDATA = wr_en ? ld_wdata : '0;
    assign ld_gnt    = ld_gnt_q;
    assign cl_gnt    = cl_gnt_q;
    assign ld_done   = ld_done_q;
    assign cl_done   = cl_done_q;
    assign ld_wready = (state_q == LD_BURST);
    assign busy      = (state_q != IDLE);
    assign cl_rvalid = rvalid_q;
    // The SRAM registers its read output, so the word is already a register
    // output in the cycle after the access; it is forwarded with rvalid.
    assign cl_rdata  = rvalid_q ? MEM_ODATA : '0;
endmodule

// File: tb/tb_nn_wmem_arbiter.sv
// tb_nn_wmem_arbiter: directed self-checking bench with a behavioural SRAM model
module tb_nn_wmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, ld_wvalid, cl_req;
    logic [4:0]  ld_addr, cl_addr;
    logic [5:0]  ld_len, cl_len;
    logic [31:0] ld_wdata;
    logic        ld_gnt, ld_wready, ld_done, cl_gnt, cl_rvalid, cl_done, busy;
    logic [31:0] cl_rdata;
    logic [4:0]  MEM_A;
    logic        MEM_CSB, MEM_WEB, MEM_OEB;
    logic [31:0] MEM_IDATA, MEM_ODATA;
    logic [31:0] mem [32];
    int n_chk = 0, n_pass = 0;
    int wr_cnt = 0, acc_cnt = 0, bad_cnt = 0;

    nn_wmem_arbiter dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_wdata(ld_wdata),
        .ld_wvalid(ld_wvalid), .ld_gnt(ld_gnt), .ld_wready(ld_wready), .ld_done(ld_done),
        .cl_req(cl_req), .cl_addr(cl_addr), .cl_len(cl_len), .cl_gnt(cl_gnt),
        .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid), .cl_done(cl_done),
        .MEM_A(MEM_A), .MEM_CSB(MEM_CSB), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
        .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!MEM_CSB && !MEM_WEB) begin
            mem[MEM_A] <= MEM_IDATA;
            wr_cnt <= wr_cnt + 1;
        end
        if (!MEM_CSB && !MEM_OEB) MEM_ODATA <= mem[MEM_A];
        if (!MEM_CSB) acc_cnt <= acc_cnt + 1;
        if (!MEM_WEB && !MEM_OEB) bad_cnt <= bad_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ld_burst(input logic [4:0] a, input logic [5:0] n, input int ne,
                            input logic [31:0] d0, input logic [31:0] pat);
        int k, j, w0;
        logic [4:0] ea;
        k = 0; j = 0; w0 = wr_cnt;
        ld_req = 1'b1; ld_addr = a; ld_len = n;
        tick();
        check("ld_gnt", ld_gnt, 1);
        ld_req = 1'b0;
        for (int c = 0; c < 200 && k < ne; c++) begin
            tick();
            if (ld_wready) begin
                ld_wvalid = (j < 32) ? pat[j] : 1'b1;
                ld_wdata  = d0 + k;
                #1;
                check("ld_csb", MEM_CSB, !ld_wvalid);
                if (ld_wvalid) begin
                    ea = a + k[4:0];
                    check("ld_web", MEM_WEB, 0);
                    check("ld_addr", MEM_A, ea);
                    k++;
                end
                j++;
            end
        end
        tick();
        ld_wvalid = 1'b0;
        check("ld_done", ld_done, 1);
        check("ld_wready_fall", ld_wready, 0);
        check("ld_busy_idle", busy, 0);
        check("ld_nwrites", wr_cnt - w0, ne);
        for (int i = 0; i < ne; i++) begin
            ea = a + 5'(i);
            check("ld_mem", mem[ea], d0 + i);
        end
    endtask

    task automatic cl_burst(input logic [4:0] a, input logic [5:0] n, input logic [31:0] d0);
        int nn;
        nn = int'(n);
        cl_req = 1'b1; cl_addr = a; cl_len = n;
        tick();
        check("cl_gnt", cl_gnt, 1);
        cl_req = 1'b0;
        for (int c = 1; c <= nn + 2; c++) begin
            tick();
            check("cl_rvalid", cl_rvalid, (c >= 2 && c <= nn + 1));
            if (c >= 2 && c <= nn + 1) check("cl_rdata", cl_rdata, d0 + c - 2);
            check("cl_done", cl_done, c == nn + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ord, ord_exp;
        int ng, got, a0;
        rst = 1'b1; ld_req = 0; cl_req = 0; ld_wvalid = 0;
        ld_addr = 0; cl_addr = 0; ld_len = 0; cl_len = 0; ld_wdata = 0;
        tick(); tick();
        check("rst_ctrl", {MEM_CSB, MEM_WEB, MEM_OEB}, 3'b111);
        check("rst_a_idata", {MEM_A, MEM_IDATA}, 0);
        check("rst_flags", {ld_gnt, ld_wready, ld_done, cl_gnt, cl_rvalid, cl_done, busy}, 0);
        check("rst_rdata", cl_rdata, 0);
        rst = 1'b0;
        tick();
        ld_burst(5'd3, 6'd4, 4, 32'hA0, 32'hFFFF_FFFF);
        cl_burst(5'd3, 6'd4, 32'hA0);
        ld_burst(5'd30, 6'd4, 4, 32'hB0, 32'hFFFF_FFFF);
        cl_burst(5'd30, 6'd4, 32'hB0);
        ld_burst(5'd10, 6'd3, 3, 32'hC0, 32'b11001);
        cl_burst(5'd10, 6'd3, 32'hC0);
        ord = 0; ng = 0;
        ld_addr = 5'd20; cl_addr = 5'd20; ld_len = 6'd1; cl_len = 6'd1;
        ld_wdata = 32'hE0; ld_wvalid = 1'b1; ld_req = 1'b1; cl_req = 1'b1;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            tick();
            if (ld_gnt) begin ord = {ord[3:0], 2'd1}; ng++; ld_req = 1'b0; end
            if (cl_gnt) begin ord = {ord[3:0], 2'd2}; ng++; cl_req = 1'b0; end
            if (ld_done && ng < 3) ld_req = 1'b1;
        end
        cl_req = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            tick();
            if (ld_done) got = 1;
        end
        ld_wvalid = 1'b0;
        tick();
`ifdef LEARN_PRIORITY_EN
        ord_exp = 6'b01_01_01;
`else
        ord_exp = 6'b01_10_01;
`endif
        check("arb_ngrants", ng, 3);
        check("arb_order", ord, ord_exp);
        check("arb_ld_done", got, 1);
        a0 = acc_cnt;
        cl_burst(5'd9, 6'd0, 32'h0);
        check("len0_no_access", acc_cnt - a0, 0);
        cl_req = 1'b1; cl_addr = 5'd0; cl_len = 6'd8;
        tick();
        check("rr_cl_gnt", cl_gnt, 1);
        cl_req = 1'b0;
        tick(); tick();
        check("rr_reading", MEM_OEB, 0);
        rst = 1'b1;
        tick();
        check("rr_ctrl", {MEM_CSB, MEM_OEB}, 2'b11);
        check("rr_busy", busy, 0);
        check("rr_no_done", {cl_done, cl_rvalid}, 0);
        rst = 1'b0;
        tick();
        ld_burst(5'd7, 6'd1, 1, 32'hD0, 32'hFFFF_FFFF);
        ld_burst(5'd0, 6'd40, 32, 32'h100, 32'hFFFF_FFFF);
        cl_burst(5'd0, 6'd32, 32'h100);
        check("web_oeb_never_both_low", bad_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
